fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with IF/ID register and one-entry hold buffer
// Optional wait-cycle counter port fetch_wait_cnt is built when FETCH_PERF_EN is defined.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_wait_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_instr, hold_pc2;
  logic        can_accept;
  logic        load_mem, load_hold, fill_hold;
  logic [15:0] pc_plus2;

  assign can_accept = !if_id_valid || !stall;
  assign pc_plus2   = pc_addr + 16'd2;
  assign imem_addr  = pc_addr;
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    load_mem   = 1'b0;
    load_hold  = 1'b0;
    fill_hold  = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_WAIT;
      S_WAIT: begin
        imem_req = 1'b1;
        if (flush) begin
          state_nxt = imem_ready ? S_IDLE : S_DRAIN;
        end else if (imem_ready) begin
          pc_advance = (imem_data[15:12] != 4'hF);
          if (can_accept) begin
            load_mem  = 1'b1;
            state_nxt = (imem_data[15:12] == 4'hF) ? S_HALT : S_WAIT;
          end else begin
            fill_hold = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (can_accept) begin
          load_hold = 1'b1;
          state_nxt = (hold_instr[15:12] == 4'hF) ? S_HALT : S_WAIT;
        end
      end
      // The abandoned request still returns once; swallow it before refetching.
      S_DRAIN: if (imem_ready) state_nxt = S_IDLE;
      S_HALT:  if (flush) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr    <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
    end else if (load_mem) begin
      if_id_instr    <= imem_data;
      if_id_pc_plus2 <= pc_plus2;
      if_id_valid    <= 1'b1;
    end else if (load_hold) begin
      if_id_instr    <= hold_instr;
      if_id_pc_plus2 <= hold_pc2;
      if_id_valid    <= 1'b1;
    end else if (can_accept) begin
      if_id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_instr <= 16'h0000;
      hold_pc2   <= 16'h0000;
    end else if (flush) begin
      hold_instr <= 16'h0000;
      hold_pc2   <= 16'h0000;
    end else if (fill_hold) begin
      hold_instr <= imem_data;
      hold_pc2   <= pc_plus2;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_wait_cnt <= 16'h0000;
    else if (imem_req && !imem_ready && fetch_wait_cnt != 16'hFFFF)
      fetch_wait_cnt <= fetch_wait_cnt + 16'd1;
  end
`endif

endmodule
